// File: rtl/z_core_mul_ctrl_pkg.sv
// Shared definitions for the RV32M multiply sequencer: funct3 codes, FSM states, signedness decode.
package z_core_mul_ctrl_pkg;

  localparam logic [1:0] F3_MUL    = 2'b00;
  localparam logic [1:0] F3_MULH   = 2'b01;
  localparam logic [1:0] F3_MULHSU = 2'b10;
  localparam logic [1:0] F3_MULHU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic f3_op1_signed(input logic [1:0] f);
    return (f == F3_MULH) || (f == F3_MULHSU);
  endfunction

  function automatic logic f3_op2_signed(input logic [1:0] f);
    return (f == F3_MULH);
  endfunction

endpackage

// File: rtl/z_core_mul_ctrl_mult.sv
// Combinational 32x32->64 multiplier with independent operand signedness.
// Relies on stable inputs for LATENCY cycles (multicycle path owned by z_core_mul_ctrl).
module z_core_mult_unit (
  input  logic        op1_signed,
  input  logic        op2_signed,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  output logic [63:0] prod
);

  logic signed [32:0] a, b;
  logic signed [65:0] p;
  logic [1:0]         unused_hi;

  // A 33rd bit carries the sign only when the operand is signed, so one signed multiply covers all mixes.
  assign a = {op1_signed & op1[31], op1};
  assign b = {op2_signed & op2[31], op2};
  assign p = a * b;
  assign {unused_hi, prod} = p;

endmodule

// File: rtl/z_core_mul_ctrl.sv
// RV32M MUL/MULH/MULHSU/MULHU sequencer: valid/ready request, LATENCY-cycle hold, valid/ready response.
// Optional feature: define Z_CORE_MUL_ZERO_BYPASS_EN to short-circuit ops with a zero operand.
module z_core_mul_ctrl
  import z_core_mul_ctrl_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        busy
);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [1:0]  f_q, f_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic [63:0] prod;
  logic        accept;
  logic        unused_f3;

  assign unused_f3 = req_funct3[2];

  z_core_mult_unit u_mult (
    .op1_signed (f3_op1_signed(f_q)),
    .op2_signed (f3_op2_signed(f_q)),
    .op1        (op1_q),
    .op2        (op2_q),
    .prod       (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      f_q         <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      f_q         <= f_d;
      resp_data_q <= resp_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    f_d         = f_q;
    resp_data_d = resp_data_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op1_d   = req_rs1;
            op2_d   = req_rs2;
            f_d     = req_funct3[1:0];
            cnt_d   = 4'(LATENCY - 1);
            state_d = S_CALC;
`ifdef Z_CORE_MUL_ZERO_BYPASS_EN
            if (req_rs1 == '0 || req_rs2 == '0) begin
              resp_data_d = '0;
              state_d     = S_DONE;
            end
`endif
          end else if (state_q == S_DONE && resp_ready) begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (cnt_q == '0) begin
            resp_data_d = (f_q == F3_MUL) ? prod[31:0] : prod[63:32];
            state_d     = S_DONE;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = !flush && (state_q == S_IDLE || (state_q == S_DONE && resp_ready));
    accept     = req_ready && req_valid;
    resp_valid = (state_q == S_DONE);
    busy       = (state_q != S_IDLE);
    resp_data  = resp_data_q;
  end

endmodule

// File: tb/tb_z_core_mul_ctrl.sv
// Randomized self-checking bench for z_core_mul_ctrl against an integer-arithmetic reference model.
module tb_z_core_mul_ctrl;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  z_core_mul_ctrl #(.LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_funct3(req_funct3),
    .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // Product as mathematical integers; the low 64 bits of a 64-bit wrap are exact.
  function automatic logic [31:0] ref_mul(input logic [1:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = (f == 2'b01 || f == 2'b10) ? longint'($signed(a)) : longint'({32'h0, a});
    sb = (f == 2'b01) ? longint'($signed(b)) : longint'({32'h0, b});
    p  = 64'(sa * sb);
    return (f == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int exp_lat(input logic [31:0] a, input logic [31:0] b);
`ifdef Z_CORE_MUL_ZERO_BYPASS_EN
    if (a == 0 || b == 0) return 1;
`endif
    return LAT;
  endfunction

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1; req_funct3 = f; req_rs1 = a; req_rs2 = b;
    #1 chk("req_ready_on_issue", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
  endtask

  task automatic wait_resp(input int lat, input logic [31:0] exp);
    int n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", 64'(n), 64'(lat));
    chk("resp_data", resp_data, exp);
  endtask

  task automatic drain(input int hold, input logic [31:0] exp);
    resp_ready = 1'b0;
    repeat (hold) begin
      @(posedge clk); #1;
      chk("held_valid", resp_valid, 1);
      chk("held_data", resp_data, exp);
      chk("held_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    #1 chk("req_ready_done_rr", req_ready, 1);
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("valid_after_hs", resp_valid, 0);
    chk("busy_after_hs", busy, 0);
  endtask

  task automatic full_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    issue(f, a, b);
    wait_resp(exp_lat(a, b), ref_mul(f[1:0], a, b));
    drain(hold, ref_mul(f[1:0], a, b));
  endtask

  initial begin
    logic [31:0] a, b;
    logic [2:0]  f;

    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_req_ready", req_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Directed product cases
    full_op(3'b000, 32'd7, 32'd6, 0);
    full_op(3'b001, 32'hFFFF_FFF6, 32'h0000_0005, 0);
    full_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    full_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    full_op(3'b001, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    full_op(3'b111, 32'h0, 32'h1234_5678, 0);
    full_op(3'b100, 32'h1234_5678, 32'h0, 0);

    // Backpressure then back-to-back accept on the releasing edge
    issue(3'b000, 32'd1000, 32'd3);
    wait_resp(LAT, 32'd3000);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", resp_valid, 1);
      chk("bp_data", resp_data, 32'd3000);
      chk("bp_req_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    req_valid = 1'b1; req_funct3 = 3'b011; req_rs1 = 32'hDEAD_BEEF; req_rs2 = 32'h1000_0001;
    #1 chk("b2b_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0; resp_ready = 1'b0;
    chk("b2b_busy", busy, 1);
    chk("b2b_valid_drop", resp_valid, 0);
    wait_resp(LAT, ref_mul(2'b11, 32'hDEAD_BEEF, 32'h1000_0001));
    drain(0, ref_mul(2'b11, 32'hDEAD_BEEF, 32'h1000_0001));

    // Flush while in CALC; a simultaneous request must be refused
    issue(3'b001, 32'h1234, 32'h5678);
    flush = 1'b1; req_valid = 1'b1;
    #1 chk("flush_req_ready", req_ready, 0);
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    chk("flush_calc_busy", busy, 0);
    repeat (LAT + 1) begin
      @(posedge clk); #1;
      chk("flush_calc_novalid", resp_valid, 0);
    end
    full_op(3'b000, 32'h0001_0001, 32'h0001_0001, 0);

    // Flush while in DONE
    issue(3'b000, 32'd9, 32'd9);
    wait_resp(LAT, 32'd81);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_done_valid", resp_valid, 0);
    chk("flush_done_busy", busy, 0);
    full_op(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Async reset between edges mid-CALC
    issue(3'b011, 32'hFFFF_0000, 32'h0000_FFFF);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", resp_valid, 0);
    chk("arst_data", resp_data, 0);
    chk("arst_req_ready", req_ready, 1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_still_idle", busy, 0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = pick_op();
      b = pick_op();
      full_op(f, a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
